// File: rtl/timer_bank_pkg.sv
// Shared constants and mode encoding for the timer bank and its users.
package timer_bank_pkg;

  localparam int TB_N_CH  = 4;
  localparam int TB_CNT_W = 32;
  localparam int TB_PRE_W = 8;

  typedef enum logic {TB_PERIODIC, TB_ONESHOT} tb_mode_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: count/armed/done registers with clr > start > advance > hold priority.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int CNT_W = TB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             en,
  input  logic             clr,
  input  logic             start,
  input  logic             oneshot,
  input  logic [CNT_W-1:0] lim,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic             running
);

  logic             armed;
  logic             active;
  logic [CNT_W-1:0] last;

  // A zero limit behaves as one, so the terminal count never underflows.
  assign last    = (lim == '0) ? '0 : lim - 1'b1;
  assign active  = en & (oneshot ? armed : 1'b1);
  assign running = oneshot ? armed : en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      armed <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        count <= '0;
        armed <= 1'b0;
      end else if (start && oneshot) begin
        count <= '0;
        armed <= 1'b1;
      end else if (active && tick) begin
        // >= rather than == so a limit lowered below the count wraps on the next tick.
        if (count >= last) begin
          count <= '0;
          done  <= 1'b1;
          if (oneshot) armed <= 1'b0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/timer_bank.sv
// Bank of independent timer channels driven by one shared free-running prescaler.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int N_CH  = TB_N_CH,
  parameter int CNT_W = TB_CNT_W,
  parameter int PRE_W = TB_PRE_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PRE_W-1:0]           prescale,
  input  logic [N_CH-1:0]            en,
  input  logic [N_CH-1:0]            clr,
  input  logic [N_CH-1:0]            start,
  input  logic [N_CH-1:0]            oneshot,
  input  logic [N_CH-1:0][CNT_W-1:0] lim,
  output logic [N_CH-1:0][CNT_W-1:0] count,
  output logic [N_CH-1:0]            done,
  output logic [N_CH-1:0]            running
);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  // >= lets a mid-run decrease of prescale tick on the very next clock.
  assign tick = (pre_cnt >= prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .en      (en[i]),
      .clr     (clr[i]),
      .start   (start[i]),
      .oneshot (oneshot[i]),
      .lim     (lim[i]),
      .count   (count[i]),
      .done    (done[i]),
      .running (running[i])
    );
  end

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: a cycle model predicts every output each clock.
module tb_timer_bank;
  import timer_bank_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           prescale;
  logic [3:0]           en, clr, start, oneshot;
  logic [3:0][31:0]     lim;
  logic [3:0][31:0]     count;
  logic [3:0]           done, running;

  timer_bank #(.N_CH(4), .CNT_W(32), .PRE_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .prescale (prescale),
    .en       (en),
    .clr      (clr),
    .start    (start),
    .oneshot  (oneshot),
    .lim      (lim),
    .count    (count),
    .done     (done),
    .running  (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][31:0] count;
    logic [3:0]       done;
    logic [3:0]       running;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int pulses[4];

  // reference model state
  longint unsigned m_pre;
  longint unsigned m_count[4];
  bit              m_armed[4];
  bit              m_done[4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pre = 0;
    for (int i = 0; i < 4; i++) begin
      m_count[i] = 0; m_armed[i] = 0; m_done[i] = 0;
    end
  endtask

  // Advance the model with the inputs now applied, push the prediction,
  // clock the DUT, then pop and compare.
  task automatic step();
    exp_t e;
    exp_t got;
    bit tk;
    longint unsigned l_eff;
    tk = (m_pre >= longint'(prescale));
    m_pre = tk ? 0 : m_pre + 1;
    for (int i = 0; i < 4; i++) begin
      l_eff = (lim[i] == 0) ? 1 : longint'(lim[i]);
      m_done[i] = 0;
      if (clr[i]) begin
        m_count[i] = 0; m_armed[i] = 0;
      end else if (start[i] && oneshot[i]) begin
        m_count[i] = 0; m_armed[i] = 1;
      end else if (en[i] && (!oneshot[i] || m_armed[i]) && tk) begin
        if (m_count[i] + 1 >= l_eff) begin
          m_count[i] = 0; m_done[i] = 1;
          if (oneshot[i]) m_armed[i] = 0;
        end else begin
          m_count[i] = m_count[i] + 1;
        end
      end
      e.count[i]   = m_count[i][31:0];
      e.done[i]    = m_done[i];
      e.running[i] = oneshot[i] ? m_armed[i] : en[i];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("count%0d", i), 64'(count[i]), 64'(got.count[i]));
      check($sformatf("done%0d", i), 64'(done[i]), 64'(got.done[i]));
      check($sformatf("running%0d", i), 64'(running[i]), 64'(got.running[i]));
      if (done[i]) pulses[i]++;
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < 4; i++) pulses[i] = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; prescale = 8'd0; en = '0; clr = '0; start = '0; oneshot = '0;
    lim = '0;
    model_reset();
    clear_pulses();
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_running", 64'(running), 64'd0);
    rst = 1'b0;

    // periodic baseline
    lim[0] = 32'd4; en = 4'b0001;
    steps(12);
    check("base_pulses", 64'(pulses[0]), 64'd3);

    // prescale and pause
    clr = 4'b0001; step(); clr = '0;
    prescale = 8'd2; lim[0] = 32'd3; clear_pulses();
    steps(27);
    check("pre_pulses", 64'(pulses[0]), 64'd3);
    steps(4);
    en[0] = 1'b0; clear_pulses();
    steps(5);
    check("pause_pulses", 64'(pulses[0]), 64'd0);
    en[0] = 1'b1;
    steps(9);
    check("resume_pulses", 64'(pulses[0]), 64'd1);

    // one-shot on channel 1
    prescale = 8'd0; oneshot[1] = TB_ONESHOT; lim[1] = 32'd5; en[1] = 1'b1;
    clear_pulses();
    start[1] = 1'b1; step(); start[1] = 1'b0;
    check("os_running", 64'(running[1]), 64'd1);
    steps(8);
    check("os_pulses", 64'(pulses[1]), 64'd1);
    check("os_idle_count", 64'(count[1]), 64'd0);
    start[1] = 1'b1; step(); start[1] = 1'b0;
    steps(3);
    start[1] = 1'b1; step(); start[1] = 1'b0;
    clear_pulses();
    steps(4);
    check("os_restart_pulses", 64'(pulses[1]), 64'd0);
    steps(1);
    check("os_restart_done", 64'(done[1]), 64'd1);

    // priority: clr with start mid-run, clr in the wrap cycle
    start[1] = 1'b1; step(); start[1] = 1'b0;
    steps(2);
    clr[1] = 1'b1; start[1] = 1'b1; step(); clr[1] = 1'b0; start[1] = 1'b0;
    check("clr_start_running", 64'(running[1]), 64'd0);
    check("clr_start_count", 64'(count[1]), 64'd0);
    lim[0] = 32'd4;
    clr[0] = 1'b1; step(); clr[0] = 1'b0;
    steps(3);
    clr[0] = 1'b1; step(); clr[0] = 1'b0;
    check("clr_wrap_done", 64'(done[0]), 64'd0);

    // limit edges
    en = 4'b1111; oneshot = '0; lim[2] = 32'd0; lim[3] = 32'd1;
    clr = 4'b1100; step(); clr = '0;
    clear_pulses();
    steps(6);
    check("lim0_pulses", 64'(pulses[2]), 64'd6);
    check("lim1_pulses", 64'(pulses[3]), 64'd6);
    lim[0] = 32'd100;
    clr[0] = 1'b1; step(); clr[0] = 1'b0;
    steps(50);
    check("lower_pre_count", 64'(count[0]), 64'd50);
    lim[0] = 32'd10; step();
    check("lower_done", 64'(done[0]), 64'd1);
    check("lower_count", 64'(count[0]), 64'd0);
    lim[1] = 32'hFFFF_FFFF;
    clr[1] = 1'b1; step(); clr[1] = 1'b0;
    steps(6);
    check("biglim_count", 64'(count[1]), 64'd6);

    // independence
    lim[0] = 32'd2; lim[1] = 32'd3; lim[2] = 32'd5; lim[3] = 32'd7;
    clr = 4'b1111; step(); clr = '0;
    clear_pulses();
    steps(210);
    check("ind_pulses0", 64'(pulses[0]), 64'd105);
    check("ind_pulses1", 64'(pulses[1]), 64'd70);
    check("ind_pulses2", 64'(pulses[2]), 64'd42);
    check("ind_pulses3", 64'(pulses[3]), 64'd30);

    // async reset between edges
    steps(3);
    #2 rst = 1'b1;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    steps(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
# timer_bank

Multi-channel, parametrised cycle counter/timer for the robot control loop: PWM periods, sensor trigger/echo windows and PID sample ticks. One shared free-running prescaler feeds N_CH independent channels. Each channel runs periodic or one-shot, pauses while its enable is low, and emits a one-cycle `done` pulse each time its count reaches the limit. The block sits between the control FSMs and the sensor/actuator interfaces.

## Interface
- `N_CH`, default 4: number of channels.
- `CNT_W`, default 32: count/limit width, unsigned.
- `PRE_W`, default 8: prescaler width.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `prescale`  in  PRE_W  a tick occurs every `prescale+1` clocks; 0 means a tick every clock.
- `en`  in  N_CH  per-channel advance enable; low means hold (pause).
- `clr`  in  N_CH  per-channel synchronous clear.
- `start`  in  N_CH  per-channel arm for one-shot; ignored in periodic mode.
- `oneshot`  in  N_CH  mode: 0 is periodic, 1 is one-shot.
- `lim`  in  N_CH×CNT_W  cycles per period in ticks; 0 is treated as 1.
- `count`  out  N_CH×CNT_W  current count, registered.
- `done`  out  N_CH  one-cycle terminal pulse, registered.
- `running`  out  N_CH  channel is counting: `en[i]` in periodic mode, the armed flag in one-shot mode.

## Operation
- **Prescaler:** register `pre_cnt`.
  - `tick = (pre_cnt >= prescale)`.
  - On tick, `pre_cnt <= 0`; otherwise it increments.
  - Free-running and shared by all channels; never gated by `en`.
  - The `>=` comparison makes a mid-run `prescale` decrease safe: the tick fires on the next clock.
- **Effective limit:** `L = (lim==0) ? 1 : lim`. Use the registered count for comparison; no `lim-1` underflow.
- **Per-channel priority each clock, highest first:**
  1. `clr`: `count<=0`, `armed<=0`, `done<=0`.
  2. `start` (one-shot only): `count<=0`, `armed<=1`. No advance in this cycle.
  3. Advance when `active && tick`, where `active = en & (oneshot ? armed : 1)`:
     - If `count >= L-1`: `count<=0`, `done<=1`. In one-shot, also `armed<=0`.
     - Otherwise `count<=count+1`.
  4. Otherwise `count` holds.
- `done` defaults to 0 every clock, so it is never high for two consecutive cycles.
- **`lim` lowered below the current count:** the next advance wraps to 0 with `done`. The count never runs past `L-1` by more than that one step.
- **`start` while already armed:** restarts from 0.
- **`start` in periodic mode:** no effect.
- **`oneshot` changed mid-count:** the new mode takes effect on the next clock. `armed` keeps its value.
- **Channels are fully independent;** the only shared resource is `tick`.

## Timing
- **Reset values:** `count=0`, `done=0`, `armed=0`, `pre_cnt=0`. Outputs are valid the first clock after `rst` deasserts.
- **Latency:**
  - `done` rises in the clock after the edge where `count==L-1` was sampled with an advance. It is coincident with `count` returning to 0.
  - Period = `L*(prescale+1)` clocks in steady state.
- **First period after `en` rises:** may be shorter by up to `prescale` clocks, because the prescaler is not synchronised to `en`.
- **One-shot:** `start` in cycle t gives `armed=1` at t+1.
  - First increment at the first tick at or after t+1.
  - `done` after L ticks; `running` falls in the same cycle `done` rises.
- **Reset mid-operation:** all channels and the prescaler return to reset values immediately (asynchronous). No `done` pulse is generated.

## Structure
- **`timer_bank_pkg`:**
  - Default constants `TB_N_CH`, `TB_CNT_W`, `TB_PRE_W`.
  - `typedef enum logic {TB_PERIODIC, TB_ONESHOT} tb_mode_e` for bench readability.
- **`timer_channel`:** one sub-module holding the `count`/`armed`/`done` registers and priority logic. Parameter `CNT_W`; inputs `tick`, `en`, `clr`, `start`, `oneshot`, `lim`.
- **`timer_bank`:** holds the prescaler and a generate loop of N_CH `timer_channel` instances.

## Test plan
- **Periodic baseline:** `prescale=0`, `lim[0]=4`, `en[0]=1` → count sequence 0,1,2,3,0,…; `done[0]` high exactly every 4th clock, coincident with count=0.
- **Prescale and pause:** `prescale=2`, `lim=3` → `done` every 9 clocks. Drop `en` for 5 clocks mid-count → count frozen, next `done` delayed by 5 clocks (±prescale alignment).
- **One-shot:** `oneshot=1`, `lim=5`, pulse `start` → `running` high for 5 ticks, single `done`, count stays 0. A second `start` during the run restarts from 0.
- **Priority:** assert `clr` and `start` together during a run → count=0, armed=0, no `done`. Assert `clr` in the wrap cycle → no `done`.
- **Limit edges:**
  - `lim=0` and `lim=1` → `done` every tick, count stays 0.
  - Lower `lim` from 100 to 10 while count=50 → wrap with `done` on the next tick.
  - `lim=2^CNT_W-1` → no overflow.
- **Async reset and independence:** assert `rst` mid-count between clock edges → all outputs 0 immediately. Four channels with `lim` 2/3/5/7 → independent `done` patterns.
